// File: rtl/fetch_unit_pkg.sv
// Shared fetch/control definitions: opcode constants, fetch FSM states, default widths.
package fetch_unit_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned INSTR_W_DEF = 32;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ALU = 4'b1111;

  typedef enum logic [1:0] {
    StFetch,
    StDrain,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect.sv
// Redirect decision and target select from decoder controls and ALU flags.
module fetch_redirect #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              branchZero,
  input  logic              branchNeg,
  input  logic              jump,
  input  logic              jumpMem,
  input  logic              zeroFlag,
  input  logic              negFlag,
  input  logic [ADDR_W-1:0] regTarget,
  input  logic [ADDR_W-1:0] memTarget,
  output logic              redirect,
  output logic [ADDR_W-1:0] target
);

  assign redirect = jumpMem | jump | (branchNeg & negFlag) | (branchZero & zeroFlag);
  // jumpMem outranks every regTarget-based redirect
  assign target   = jumpMem ? memTarget : regTarget;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem request handshake, IF/ID register with one-entry skid.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter logic [3:0]  NOP_OP  = OP_NOP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               branchZero,
  input  logic               branchNeg,
  input  logic               jump,
  input  logic               jumpMem,
  input  logic               zeroFlag,
  input  logic               negFlag,
  input  logic [ADDR_W-1:0]  regTarget,
  input  logic [ADDR_W-1:0]  memTarget,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  pcOut,
  output logic               instrValid
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  tgt_q, tgt_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [ADDR_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] skid_q, skid_d;
  logic               valid_q, valid_d;
  logic               started_q;

  logic              redirect;
  logic [ADDR_W-1:0] target;
  logic              fetch_req;
  logic              ack;

  fetch_redirect #(
    .ADDR_W(ADDR_W)
  ) u_redirect (
    .branchZero(branchZero),
    .branchNeg (branchNeg),
    .jump      (jump),
    .jumpMem   (jumpMem),
    .zeroFlag  (zeroFlag),
    .negFlag   (negFlag),
    .regTarget (regTarget),
    .memTarget (memTarget),
    .redirect  (redirect),
    .target    (target)
  );

  // started_q holds the request low for the first cycle out of reset
  assign fetch_req = started_q && (state_q != StHold);
  assign ack       = imem_ack && fetch_req;

  // Next-state: PC, FSM, IF/ID and skid updates
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pc_out_d  = pc_out_q;
    skid_pc_d = skid_pc_q;
    instr_d   = instr_q;
    skid_d    = skid_q;
    valid_d   = valid_q;
    case (state_q)
      StFetch: begin
        if (!started_q) begin
          // No request in flight yet, so a redirect can take effect directly
          if (redirect) begin
            pc_d    = target;
            valid_d = 1'b0;
          end
        end else if (redirect) begin
          valid_d = 1'b0;
          if (ack) begin
            pc_d = target;
          end else begin
            tgt_d   = target;
            state_d = StDrain;
          end
        end else if (ack) begin
          pc_d = pc_q + ADDR_W'(1);
          if (stall) begin
            skid_d    = imem_rdata;
            skid_pc_d = pc_q;
            state_d   = StHold;
          end else begin
            instr_d  = imem_rdata;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
      StDrain: begin
        // Outstanding wrong-path response is swallowed; newest redirect wins
        if (redirect) begin
          tgt_d   = target;
          valid_d = 1'b0;
        end
        if (ack) begin
          pc_d    = redirect ? target : tgt_q;
          state_d = StFetch;
        end
      end
      StHold: begin
        if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!stall) begin
          instr_d  = skid_q;
          pc_out_d = skid_pc_q;
          valid_d  = 1'b1;
          state_d  = StFetch;
        end
      end
      default: state_d = StFetch;
    endcase
  end

  // State register for PC, FSM, IF/ID and skid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      tgt_q     <= '0;
      pc_out_q  <= '0;
      skid_pc_q <= '0;
      instr_q   <= '0;
      skid_q    <= '0;
      valid_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      pc_out_q  <= pc_out_d;
      skid_pc_q <= skid_pc_d;
      instr_q   <= instr_d;
      skid_q    <= skid_d;
      valid_q   <= valid_d;
      started_q <= 1'b1;
    end
  end

  // Outputs; the address stays on pc_q so it is stable for the whole request
  assign imem_req   = fetch_req;
  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign pcOut      = pc_out_q;
  assign instrValid = valid_q;
  assign opcode     = valid_q ? instr_q[INSTR_W-1 -: 4] : NOP_OP;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall, branchZero, branchNeg, jump, jumpMem, zeroFlag, negFlag;
  logic [7:0]  regTarget, memTarget;
  logic [31:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  pcOut;
  logic        instrValid;

  int unsigned lat    = 0;
  int unsigned wait_q = 0;
  int          checks = 0;
  int          errors = 0;

  fetch_unit u_dut (
    .clk       (clk),
    .rst       (rst),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .stall     (stall),
    .branchZero(branchZero),
    .branchNeg (branchNeg),
    .jump      (jump),
    .jumpMem   (jumpMem),
    .zeroFlag  (zeroFlag),
    .negFlag   (negFlag),
    .regTarget (regTarget),
    .memTarget (memTarget),
    .instr     (instr),
    .opcode    (opcode),
    .pcOut     (pcOut),
    .instrValid(instrValid)
  );

  always #5 clk = ~clk;

  // Memory word encodes its own address; opcode = F ^ addr[7:4]
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {4'hF ^ a[7:4], 20'h00000, a};
  endfunction

  // Memory acks once a request has been held for lat prior cycles
  always @(posedge clk) begin
    if (imem_req && imem_ack) wait_q <= 0;
    else if (imem_req)        wait_q <= wait_q + 1;
    else                      wait_q <= 0;
  end

  always_comb begin
    imem_ack   = imem_req && (wait_q >= lat);
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; branchZero = 0; branchNeg = 0; jump = 0; jumpMem = 0;
    zeroFlag = 0; negFlag = 0; regTarget = 8'h00; memTarget = 8'h00;
    tick();
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_req: got %b want 0", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin errors++;
      $display("FAIL rst_addr: got %h want 00", imem_addr); end
    checks++; if (instr !== 32'h0 || pcOut !== 8'h00) begin errors++;
      $display("FAIL rst_ifid: got instr %h pc %h want 0/0", instr, pcOut); end
    checks++; if (instrValid !== 1'b0 || opcode !== 4'h0) begin errors++;
      $display("FAIL rst_valid: got v %b op %h want 0/0", instrValid, opcode); end
    rst = 1'b0;
    checks++; if (imem_req !== 1'b0) begin errors++;
      $display("FAIL rst_release_req: got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instrValid !== 1'b0) begin
      errors++; $display("FAIL first_req: got req %b addr %h v %b want 1/00/0",
                         imem_req, imem_addr, instrValid); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (instrValid !== 1'b1 || pcOut !== 8'(k)) begin errors++;
        $display("FAIL seq_pc[%0d]: got v %b pc %h want 1/%h", k, instrValid, pcOut, 8'(k)); end
      checks++; if (instr !== mem_word(8'(k)) || opcode !== 4'hF) begin errors++;
        $display("FAIL seq_instr[%0d]: got %h op %h want %h/F", k, instr, opcode,
                 mem_word(8'(k))); end
      checks++; if (imem_addr !== 8'(k + 1)) begin errors++;
        $display("FAIL seq_addr[%0d]: got %h want %h", k, imem_addr, 8'(k + 1)); end
    end
  endtask

  task automatic test_stall();
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pcOut !== 8'h04 || instr !== mem_word(8'h04) || instrValid !== 1'b1) begin
        errors++; $display("FAIL stall_hold[%0d]: got pc %h instr %h v %b want 04/%h/1",
                           k, pcOut, instr, instrValid, mem_word(8'h04)); end
      checks++; if (imem_req !== 1'b0) begin errors++;
        $display("FAIL stall_req[%0d]: got %b want 0", k, imem_req); end
    end
    stall = 1'b0;
    tick();
    checks++; if (pcOut !== 8'h05 || instr !== mem_word(8'h05) || instrValid !== 1'b1) begin
      errors++; $display("FAIL stall_skid: got pc %h instr %h v %b want 05/%h/1",
                         pcOut, instr, instrValid, mem_word(8'h05)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h06) begin errors++;
      $display("FAIL stall_resume: got req %b addr %h want 1/06", imem_req, imem_addr); end
    tick();
    checks++; if (pcOut !== 8'h06 || imem_addr !== 8'h07) begin errors++;
      $display("FAIL stall_after: got pc %h addr %h want 06/07", pcOut, imem_addr); end
  endtask

  task automatic test_branch();
    tick();
    tick();
    branchZero = 1'b1; zeroFlag = 1'b0; regTarget = 8'h40;
    tick();
    checks++; if (imem_addr !== 8'h0A || pcOut !== 8'h09) begin errors++;
      $display("FAIL br_not_taken: got addr %h pc %h want 0A/09", imem_addr, pcOut); end
    zeroFlag = 1'b1;
    tick();
    checks++; if (imem_addr !== 8'h40 || instrValid !== 1'b0 || opcode !== 4'h0) begin
      errors++; $display("FAIL br_taken: got addr %h v %b op %h want 40/0/0",
                         imem_addr, instrValid, opcode); end
    branchZero = 1'b0; zeroFlag = 1'b0;
    tick();
    checks++; if (pcOut !== 8'h40 || instrValid !== 1'b1 || opcode !== 4'hB) begin errors++;
      $display("FAIL br_target: got pc %h v %b op %h want 40/1/B", pcOut, instrValid, opcode); end
    branchNeg = 1'b1; negFlag = 1'b1; regTarget = 8'h08;
    tick();
    checks++; if (imem_addr !== 8'h08 || instrValid !== 1'b0) begin errors++;
      $display("FAIL br_neg: got addr %h v %b want 08/0", imem_addr, instrValid); end
    branchNeg = 1'b0; negFlag = 1'b0;
    tick();
    checks++; if (pcOut !== 8'h08 || imem_addr !== 8'h09) begin errors++;
      $display("FAIL br_neg_after: got pc %h addr %h want 08/09", pcOut, imem_addr); end
  endtask

  task automatic test_drain();
    lat = 2;
    jumpMem = 1'b1; memTarget = 8'h20; jump = 1'b1; regTarget = 8'h77;
    tick();
    jumpMem = 1'b0; jump = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h09 || instrValid !== 1'b0) begin
      errors++; $display("FAIL drain_hold: got req %b addr %h v %b want 1/09/0",
                         imem_req, imem_addr, instrValid); end
    tick();
    tick();
    checks++; if (imem_addr !== 8'h20 || instrValid !== 1'b0) begin errors++;
      $display("FAIL drain_target: got addr %h v %b want 20/0", imem_addr, instrValid); end
    tick();
    tick();
    checks++; if (instrValid !== 1'b0) begin errors++;
      $display("FAIL drain_wait: got v %b want 0", instrValid); end
    tick();
    checks++; if (pcOut !== 8'h20 || instrValid !== 1'b1 || instr !== mem_word(8'h20)) begin
      errors++; $display("FAIL drain_fetch: got pc %h v %b instr %h want 20/1/%h",
                         pcOut, instrValid, instr, mem_word(8'h20)); end
    jumpMem = 1'b1; memTarget = 8'h50;
    tick();
    jumpMem = 1'b0; jump = 1'b1; regTarget = 8'h30;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 8'h21 || imem_req !== 1'b1) begin errors++;
      $display("FAIL drain2_hold: got addr %h req %b want 21/1", imem_addr, imem_req); end
    tick();
    checks++; if (imem_addr !== 8'h30 || instrValid !== 1'b0) begin errors++;
      $display("FAIL drain2_newest: got addr %h v %b want 30/0", imem_addr, instrValid); end
  endtask

  task automatic test_wrap();
    lat = 0;
    jump = 1'b1; regTarget = 8'hFF;
    tick();
    jump = 1'b0;
    checks++; if (imem_addr !== 8'hFF) begin errors++;
      $display("FAIL wrap_jump: got %h want FF", imem_addr); end
    tick();
    checks++; if (pcOut !== 8'hFF || instrValid !== 1'b1 || instr !== mem_word(8'hFF)) begin
      errors++; $display("FAIL wrap_ifid: got pc %h v %b instr %h want FF/1/%h",
                         pcOut, instrValid, instr, mem_word(8'hFF)); end
    checks++; if (imem_addr !== 8'h00) begin errors++;
      $display("FAIL wrap_addr: got %h want 00", imem_addr); end
  endtask

  task automatic test_async_reset();
    lat = 2;
    jump = 1'b1; regTarget = 8'h10;
    tick();
    jump = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || pcOut !== 8'h00) begin errors++;
      $display("FAIL arst_ctl: got req %b addr %h pc %h want 0/00/00",
               imem_req, imem_addr, pcOut); end
    checks++; if (instr !== 32'h0 || instrValid !== 1'b0 || opcode !== 4'h0) begin errors++;
      $display("FAIL arst_ifid: got instr %h v %b op %h want 0/0/0", instr, instrValid, opcode);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin errors++;
      $display("FAIL arst_restart: got req %b addr %h want 1/00", imem_req, imem_addr); end
    tick();
    tick();
    tick();
    checks++; if (pcOut !== 8'h00 || instrValid !== 1'b1 || imem_addr !== 8'h01) begin errors++;
      $display("FAIL arst_fetch: got pc %h v %b addr %h want 00/1/01",
               pcOut, instrValid, imem_addr); end
    tick();
    checks++; if (instrValid !== 1'b0 || opcode !== 4'h0) begin errors++;
      $display("FAIL bubble: got v %b op %h want 0/0", instrValid, opcode); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_drain();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
